// File: rtl/param_sync_fifo.sv
// Single-clock FIFO using all DEPTH entries via an extra pointer MSB.
// Adds fill count, almost flags, flush, sticky errors and show-ahead/registered read.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic          wr_acc, rd_acc;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  always_comb begin
    wr_acc   = wr_en & ~full_q & ~flush;
    rd_acc   = rd_en & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= AF_L);
    ae_d    = (count_d <= AE_L);
    // A set event in the same cycle as clr_err leaves the flag set.
    overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full_q  & ~flush);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & empty_q & ~flush);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetb && wr_acc) mem_q[wr_idx] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    // Zero while empty so dout reads 0 straight out of reset.
    assign dout_valid = ~empty_q;
    assign dout       = empty_q ? '0 : mem_q[rd_idx];
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    always_comb begin
      dout_d       = dout_q;
      dout_valid_d = rd_acc;
      if (rd_acc) dout_d = mem_q[rd_idx];
    end

    always_ff @(posedge clk) begin
      if (!resetb) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_q       <= dout_d;
        dout_valid_q <= dout_valid_d;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: show-ahead and registered-read instances driven in lockstep
// and compared against a queue-based model, plus a vector table and directed corner cases.
module tb_param_sync_fifo;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetb = 1'b0, flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] f_dout, r_dout;
  logic         f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic         r_dv, r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [AW:0]  f_count, r_count;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .resetb(resetb), .flush(flush), .clr_err(clr_err), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .dout(f_dout), .dout_valid(f_dv), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk(clk), .resetb(resetb), .flush(flush), .clr_err(clr_err), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .dout(r_dout), .dout_valid(r_dv), .full(r_full),
    .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_udf));

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, everything else derived from its size.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0, m_udf = 1'b0, m_rvalid = 1'b0;
  logic [W-1:0] m_rdout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit was_full, was_empty, wacc, racc;
    if (!resetb) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_rvalid = 0; m_rdout = '0;
    end else if (flush) begin
      mq.delete();
      m_rvalid = 0;
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
    end else begin
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      wacc = wr_en && !was_full;
      racc = rd_en && !was_empty;
      if (racc) begin
        m_rdout = mq[0];
        void'(mq.pop_front());
      end
      m_rvalid = racc;
      if (wacc) mq.push_back(din);
      m_ovf = (m_ovf && !clr_err) || (wr_en && was_full);
      m_udf = (m_udf && !clr_err) || (rd_en && was_empty);
    end
  endtask

  task automatic check_model();
    int cnt;
    cnt = mq.size();
    check("count_f", 32'(f_count), cnt);
    check("count_r", 32'(r_count), cnt);
    check("empty_f", 32'(f_empty), 32'(cnt == 0));
    check("empty_r", 32'(r_empty), 32'(cnt == 0));
    check("full_f", 32'(f_full), 32'(cnt == D));
    check("full_r", 32'(r_full), 32'(cnt == D));
    check("af_f", 32'(f_af), 32'(cnt >= 14));
    check("af_r", 32'(r_af), 32'(cnt >= 14));
    check("ae_f", 32'(f_ae), 32'(cnt <= 2));
    check("ae_r", 32'(r_ae), 32'(cnt <= 2));
    check("ovf_f", 32'(f_ovf), 32'(m_ovf));
    check("ovf_r", 32'(r_ovf), 32'(m_ovf));
    check("udf_f", 32'(f_udf), 32'(m_udf));
    check("udf_r", 32'(r_udf), 32'(m_udf));
    check("dv_f", 32'(f_dv), 32'(cnt != 0));
    if (cnt != 0) check("dout_f", 32'(f_dout), 32'(mq[0]));
    check("dv_r", 32'(r_dv), 32'(m_rvalid));
    check("dout_r", 32'(r_dout), 32'(m_rdout));
  endtask

  task automatic step(input logic rb, input logic fl, input logic ce,
                      input logic we, input logic re, input logic [W-1:0] d);
    resetb = rb; flush = fl; clr_err = ce; wr_en = we; rd_en = re; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic rb, fl, ce, we, re;
    logic [W-1:0] d;
    logic [AW:0]  c;
    logic e, f, o, u;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Vector table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rb, tbl[i].fl, tbl[i].ce, tbl[i].we, tbl[i].re, tbl[i].d);
      check("tbl_count", 32'(f_count), 32'(tbl[i].c));
      check("tbl_empty", 32'(f_empty), 32'(tbl[i].e));
      check("tbl_full", 32'(f_full), 32'(tbl[i].f));
      check("tbl_ovf", 32'(f_ovf), 32'(tbl[i].o));
      check("tbl_udf", 32'(r_udf), 32'(tbl[i].u));
    end

    // Reset mid-operation with random requests
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 8'($urandom));
    step(0, 0, 0, 1'($urandom), 1'($urandom), 8'($urandom));
    check("rst_count", 32'(f_count), 0);
    check("rst_empty", 32'(r_empty), 1);
    check("rst_full", 32'(f_full), 0);
    check("rst_ae", 32'(f_ae), 1);
    check("rst_af", 32'(r_af), 0);
    check("rst_dv_f", 32'(f_dv), 0);
    check("rst_dv_r", 32'(r_dv), 0);
    check("rst_dout_f", 32'(f_dout), 0);
    check("rst_dout_r", 32'(r_dout), 0);

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 0, 8'(i));
      check("fill_af", 32'(f_af), 32'(i + 1 >= 14));
      check("fill_full", 32'(f_full), 32'(i == 15));
    end
    check("fill_count", 32'(f_count), 16);
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", 32'(f_dout), 32'(i));
      step(1, 0, 0, 0, 1, 8'h00);
      check("drain_rdout", 32'(r_dout), 32'(i));
    end
    check("drain_empty", 32'(f_empty), 1);

    // Steady-state count 5 with simultaneous traffic across pointer wrap
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      check("wrap_dout", 32'(f_dout), 32'(8'(8'h80 + i)));
      step(1, 0, 0, 1, 1, 8'(8'h85 + i));
      check("wrap_count", 32'(f_count), 5);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 8'h00);

    // Overflow / underflow
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 8'(8'h30 + i));
    step(1, 0, 0, 1, 0, 8'hAA);
    check("ovf_set", 32'(f_ovf), 1);
    check("ovf_count", 32'(f_count), 16);
    step(1, 0, 1, 1, 0, 8'hAA);
    check("ovf_clr_vs_set", 32'(r_ovf), 1);
    step(1, 0, 1, 0, 0, 8'h00);
    check("ovf_cleared", 32'(f_ovf), 0);
    for (int i = 0; i < 16; i++) begin
      check("ovf_contents", 32'(f_dout), 32'(8'h30 + i));
      step(1, 0, 0, 0, 1, 8'h00);
    end
    step(1, 0, 0, 0, 1, 8'h00);
    check("udf_set", 32'(f_udf), 1);
    check("udf_dv_r", 32'(r_dv), 0);

    // Registered-read latency
    step(1, 1, 1, 0, 0, 8'h00);
    step(1, 0, 0, 1, 0, 8'h5A);
    step(1, 0, 0, 0, 1, 8'h00);
    check("lat_dout", 32'(r_dout), 32'h5A);
    check("lat_dv", 32'(r_dv), 1);
    step(1, 0, 0, 0, 0, 8'h00);
    check("lat_dv_drop", 32'(r_dv), 0);
    check("lat_hold", 32'(r_dout), 32'h5A);

    // Flush with concurrent requests, errors preserved
    step(1, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0, 8'(8'hC0 + i));
    check("pre_flush_count", 32'(f_count), 7);
    step(1, 1, 0, 1, 1, 8'hEE);
    check("flush_count", 32'(f_count), 0);
    check("flush_empty", 32'(r_empty), 1);
    check("flush_udf", 32'(f_udf), 1);
    check("flush_ovf", 32'(f_ovf), 0);
    check("flush_dv_r", 32'(r_dv), 0);

    // Randomized traffic in phases of different write/read pressure
    for (int n = 0; n < 3000; n++) begin
      int wp, rp;
      case ((n / 200) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      step(1'($urandom_range(0, 399) != 0), 1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 99) < wp),
           1'($urandom_range(0, 99) < rp), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
